// File: rtl/axi_rd_master_pkg.sv
// Shared types and constants for the AXI4 single-beat read initiator.
// Consumers: axi_rd_master (top) and load_extend (byte-lane extraction).
package axi_rd_master_pkg;

  // One-hot FSM encoding.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ADDR = 4'b0010,
    ST_DATA = 4'b0100,
    ST_RESP = 4'b1000
  } state_t;

  localparam logic [1:0]  SIZE_B         = 2'd0;
  localparam logic [1:0]  SIZE_H         = 2'd1;
  localparam logic [1:0]  SIZE_W         = 2'd2;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  localparam logic [15:0] TIMEOUT_MAX    = 16'hFFFF;

endpackage

// File: rtl/load_extend.sv
// Combinational load data extraction: picks the addressed byte/half/word out of
// a 64-bit read beat and sign- or zero-extends it to 32 bits.
module load_extend
  import axi_rd_master_pkg::*;
#(
  parameter bit LANE_ALIGNED = 1'b1
) (
  input  logic [63:0] rdata,
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [5:0]  shamt;
  logic [31:0] shifted;

  // Right-justified responders already put the addressed data at bit 0.
  assign shamt   = LANE_ALIGNED ? {addr_lo, 3'b000} : 6'd0;
  assign shifted = 32'(rdata >> shamt);

  always_comb begin
    data = shifted;
    case (size)
      SIZE_B:  data = {{24{is_signed & shifted[7]}},  shifted[7:0]};
      SIZE_H:  data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/axi_rd_master.sv
// AXI4 read initiator: one core load request -> one AR beat -> one R beat -> one result.
// Optional macro AXI_RD_TIMEOUT_EN adds a 16-bit wait timeout in ADDR/DATA.
module axi_rd_master
  import axi_rd_master_pkg::*;
#(
  parameter logic [3:0] ID           = 4'h0,
  parameter bit         LANE_ALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  // Core load request / result
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  // AXI AR channel
  output logic [31:0] araddr_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  output logic [3:0]  arid_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  // AXI R channel
  input  logic [63:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic [3:0]  rid_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  // FSM state for checkers
  output logic [3:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid is never withdrawn until its transfer, and payload is
  // held stable while valid waits for ready.

  state_t      state_q, state_d;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] ext_data;
  logic        beat_err;
  logic        accept;
  logic        r_fire;
  logic        timeout;

  assign accept   = (state_q == ST_IDLE) && req_valid_i;
  assign r_fire   = (state_q == ST_DATA) && rvalid_i;
  assign beat_err = (rresp_i != AXI_RESP_OKAY) || (rid_i != ID) || !rlast_i;

`ifdef AXI_RD_TIMEOUT_EN
  logic [15:0] wait_cnt_q;

  assign timeout = ((state_q == ST_ADDR) || (state_q == ST_DATA)) &&
                   (wait_cnt_q == TIMEOUT_MAX);

  // Restarts on every state change, so each wait phase gets a full budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_d != state_q) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ST_ADDR) || (state_q == ST_DATA)) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i)    state_d = ST_DATA;
        else if (timeout) state_d = ST_RESP;
      end
      ST_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i)     state_d = ST_RESP;
        else if (timeout) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are latched at accept so the AR payload stays stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      araddr_o   <= '0;
      size_q     <= SIZE_B;
      signed_q   <= 1'b0;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      if (accept) begin
        araddr_o <= req_addr_i;
        size_q   <= req_size_i;
        signed_q <= req_signed_i;
      end
      if (r_fire) begin
        rsp_data_o <= ext_data;
        rsp_err_o  <= beat_err;
      end else if (timeout) begin
        rsp_data_o <= '0;
        rsp_err_o  <= 1'b1;
      end
    end
  end

  load_extend #(
    .LANE_ALIGNED (LANE_ALIGNED)
  ) u_load_extend (
    .rdata     (rdata_i),
    .addr_lo   (araddr_o[2:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (ext_data)
  );

  assign arid_o      = ID;
  assign arlen_o     = 8'd0;
  assign arsize_o    = {1'b0, size_q};
  assign arburst_o   = AXI_BURST_INCR;
  assign dbg_state_o = state_q;

endmodule
